// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - gate servo dispense-cycle sequencer
// Runs open/hold/close phases per dose and drives the servo pulse-width word.
module dispense_sequencer #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter logic [19:0] POS_CLOSED = 20'd40000,
    parameter logic [19:0] POS_OPEN   = 20'd120000,
    parameter int unsigned OPEN_MS    = 300,
    parameter int unsigned HOLD_MS    = 1000,
    parameter int unsigned CLOSE_MS   = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  doses,
    input  logic        abort,
    output logic [19:0] position,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [3:0]  doses_left,
    output logic [15:0] total_count
);

    localparam logic [31:0] T_OPEN  = 32'(OPEN_MS * (CLK_HZ / 1000));
    localparam logic [31:0] T_HOLD  = 32'(HOLD_MS * (CLK_HZ / 1000));
    localparam logic [31:0] T_CLOSE = 32'(CLOSE_MS * (CLK_HZ / 1000));

    typedef enum logic [1:0] {IDLE, OPENING, HOLD, CLOSING} state_t;

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [3:0]  doses_left_n, left_eff;
    logic [15:0] total_n;
    logic        aborted_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            doses_left  <= '0;
            total_count <= '0;
            aborted     <= 1'b0;
            position    <= POS_CLOSED;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            doses_left  <= doses_left_n;
            total_count <= total_n;
            aborted     <= aborted_n;
            // Outputs are registered from the next state so they align with it.
            position    <= (state_n == OPENING || state_n == HOLD) ? POS_OPEN : POS_CLOSED;
            busy        <= (state_n != IDLE);
            done        <= (state != IDLE) && (state_n == IDLE);
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = (timer == 32'd0) ? 32'd0 : timer - 32'd1;
        doses_left_n = doses_left;
        total_n      = total_count;
        aborted_n    = aborted;
        left_eff     = abort ? 4'd1 : doses_left;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (start && doses != 4'd0 && !abort) begin
                    state_n      = OPENING;
                    timer_n      = T_OPEN - 32'd1;
                    doses_left_n = doses;
                    aborted_n    = 1'b0;
                end
            end
            OPENING, HOLD: begin
                // Abort wins over a simultaneous phase expiry.
                if (abort) begin
                    state_n      = CLOSING;
                    timer_n      = T_CLOSE - 32'd1;
                    doses_left_n = 4'd1;
                    aborted_n    = 1'b1;
                end else if (timer == 32'd0) begin
                    if (state == OPENING) begin
                        state_n = HOLD;
                        timer_n = T_HOLD - 32'd1;
                    end else begin
                        state_n = CLOSING;
                        timer_n = T_CLOSE - 32'd1;
                        total_n = (total_count != 16'hFFFF) ? total_count + 16'd1 : total_count;
                    end
                end
            end
            CLOSING: begin
                if (abort) aborted_n = 1'b1;
                doses_left_n = left_eff;
                if (timer == 32'd0) begin
                    doses_left_n = left_eff - 4'd1;
                    if (left_eff > 4'd1) begin
                        state_n = OPENING;
                        timer_n = T_OPEN - 32'd1;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - directed vector bench for dispense_sequencer
module tb_dispense_sequencer;

    localparam logic [19:0] C = 20'd40000;
    localparam logic [19:0] O = 20'd120000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  doses;
    logic        abort;
    logic [19:0] position;
    logic        busy, done, aborted;
    logic [3:0]  doses_left;
    logic [15:0] total_count;

    int total = 0;
    int bad   = 0;

    dispense_sequencer #(
        .CLK_HZ(1000), .POS_CLOSED(20'd40000), .POS_OPEN(20'd120000),
        .OPEN_MS(3), .HOLD_MS(5), .CLOSE_MS(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .doses(doses), .abort(abort),
        .position(position), .busy(busy), .done(done), .aborted(aborted),
        .doses_left(doses_left), .total_count(total_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [3:0]  d;
        logic        ab;
        logic [19:0] pos;
        logic        busy;
        logic        done;
        logic        abd;
        logic [3:0]  left;
        logic [15:0] tot;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int n, input logic st, input logic [3:0] d, input logic ab,
                       input logic [19:0] pos, input logic b, input logic dn, input logic abd,
                       input logic [3:0] l, input logic [15:0] t);
        vec_t v;
        v.st = st; v.d = d; v.ab = ab; v.pos = pos; v.busy = b;
        v.done = dn; v.abd = abd; v.left = l; v.tot = t;
        repeat (n) vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [19:0] p, input logic b, input logic dn,
                           input logic abd, input logic [3:0] l, input logic [15:0] t);
        chk({tag, ".position"}, 32'(position), 32'(p));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".aborted"}, 32'(aborted), 32'(abd));
        chk({tag, ".doses_left"}, 32'(doses_left), 32'(l));
        chk({tag, ".total_count"}, 32'(total_count), 32'(t));
    endtask

    initial begin
        // Each row: inputs driven during the cycle, outputs expected in that cycle.
        add(1, 1, 1, 0, C, 0, 0, 0, 0, 0);   // single dose start
        add(4, 0, 0, 0, O, 1, 0, 0, 1, 0);
        add(1, 1, 2, 0, O, 1, 0, 0, 1, 0);   // start while busy
        add(3, 0, 0, 0, O, 1, 0, 0, 1, 0);
        add(3, 0, 0, 0, C, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, C, 0, 1, 0, 0, 1);   // doses=0 request
        add(1, 1, 3, 1, C, 0, 0, 0, 0, 1);   // start with abort
        add(1, 1, 3, 0, C, 0, 0, 0, 0, 1);   // three doses start
        add(8, 0, 0, 0, O, 1, 0, 0, 3, 1);
        add(3, 0, 0, 0, C, 1, 0, 0, 3, 2);
        add(8, 0, 0, 0, O, 1, 0, 0, 2, 2);
        add(3, 0, 0, 0, C, 1, 0, 0, 2, 3);
        add(8, 0, 0, 0, O, 1, 0, 0, 1, 3);
        add(3, 0, 0, 0, C, 1, 0, 0, 1, 4);
        add(1, 1, 3, 0, C, 0, 1, 0, 0, 4);   // done + restart, abort scenario
        add(5, 0, 0, 0, O, 1, 0, 0, 3, 4);
        add(1, 0, 0, 1, O, 1, 0, 0, 3, 4);   // abort in HOLD
        add(3, 0, 0, 0, C, 1, 0, 1, 1, 4);
        add(1, 1, 1, 0, C, 0, 1, 1, 0, 4);   // restart clears aborted
        add(1, 0, 0, 0, O, 1, 0, 0, 1, 4);
        add(1, 0, 0, 1, O, 1, 0, 0, 1, 4);   // abort in OPENING
        add(3, 0, 0, 0, C, 1, 0, 1, 1, 4);
        add(1, 0, 0, 1, C, 0, 1, 1, 0, 4);   // abort in IDLE
        add(1, 1, 2, 0, C, 0, 0, 1, 0, 4);
        add(8, 0, 0, 0, O, 1, 0, 0, 2, 4);
        add(1, 0, 0, 1, C, 1, 0, 0, 2, 5);   // abort in CLOSING
        add(2, 0, 0, 0, C, 1, 0, 1, 1, 5);
        add(1, 0, 0, 0, C, 0, 1, 1, 0, 5);
        add(1, 0, 0, 0, C, 0, 0, 1, 0, 5);

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); doses = 4'($urandom); abort = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk_all("reset", C, 0, 0, 0, 0, 0);
        rst = 1'b0; start = 1'b0; doses = 4'd0; abort = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            chk_all($sformatf("vec%0d", i), vq[i].pos, vq[i].busy, vq[i].done,
                    vq[i].abd, vq[i].left, vq[i].tot);
            start = vq[i].st; doses = vq[i].d; abort = vq[i].ab;
            @(negedge clk);
        end

        // Reset in the middle of HOLD of a single-dose sequence.
        start = 1'b1; doses = 4'd1;
        @(negedge clk);
        start = 1'b0; doses = 4'd0;
        repeat (5) @(negedge clk);
        chk_all("midhold.c6", O, 1, 0, 0, 1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all("midhold.c7", C, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("midhold.done%0d", i), 32'(done), 32'd0);
            chk($sformatf("midhold.busy%0d", i), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
